// File: rtl/video_gen_pkg.sv
// -----------------------------------------------------------------------------
// video_gen_pkg
// Shared types and elaboration-time helpers for the video pattern generator.
//   pattern_t       : test pattern selector (H-ramp, V-ramp, checker, XOR)
//   gen_state_t     : transmitter run state
//   ceil_div()      : words needed to cover an active line
//   last_word_mask(): per-lane valid mask for the last active word of a line
// -----------------------------------------------------------------------------
package video_gen_pkg;

    typedef enum logic [1:0] {
        PAT_HRAMP   = 2'd0,
        PAT_VRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_XOR     = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    // Bit of pixel index / line index that toggles the checkerboard (32x32 tiles).
    localparam int CHECKER_BIT = 5;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Lanes holding real pixels in the last active word. A line that fills
    // its last word completely gets every lane; otherwise only the low
    // RES_X % PX_PER_CLK lanes carry pixels.
    function automatic logic [31:0] last_word_mask(input int res_x, input int px_per_clk);
        int rem;
        rem = res_x % px_per_clk;
        if (rem == 0) begin
            return 32'((64'd1 << px_per_clk) - 64'd1);
        end
        return 32'((64'd1 << rem) - 64'd1);
    endfunction

endpackage

// File: rtl/video_pattern_px.sv
// -----------------------------------------------------------------------------
// video_pattern_px
// Combinational pixel value for one lane of the pattern generator.
//   pattern : selected test pattern (latched at frame start by the caller)
//   p       : absolute pixel index within the line
//   y       : line index within the frame
//   px      : pixel value, truncated to PX_WIDTH LSBs
// P_W and Y_W must be at least CHECKER_BIT+1 so the checker bit exists.
// -----------------------------------------------------------------------------
module video_pattern_px
    import video_gen_pkg::*;
#(
    parameter int PX_WIDTH = 12,
    parameter int P_W      = 12,
    parameter int Y_W      = 11
) (
    input  pattern_t              pattern,
    input  logic [P_W-1:0]        p,
    input  logic [Y_W-1:0]        y,
    output logic [PX_WIDTH-1:0]   px
);

    logic [PX_WIDTH-1:0] p_t;
    logic [PX_WIDTH-1:0] y_t;

    assign p_t = PX_WIDTH'(p);
    assign y_t = PX_WIDTH'(y);

    always_comb begin
        // NOTE: px gets a default before the case so no path leaves it unassigned, which would infer a latch.
        px = '0;
        case (pattern)
            PAT_HRAMP:   px = p_t;
            PAT_VRAMP:   px = y_t;
            PAT_CHECKER: px = (p[CHECKER_BIT] ^ y[CHECKER_BIT]) ? '1 : '0;
            PAT_XOR:     px = p_t ^ y_t;
            default:     px = '0;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Free-running video stream transmitter: PX_PER_CLK pixels per clock with
// per-lane valid, line/frame markers, H/V blanking and a selectable pattern.
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   en_i           : run request, only looked at when idle or on the last
//                    word of a frame
//   pattern_i      : pattern select, latched at each frame start
//   px_data_o      : pixel lanes, lane 0 = leftmost pixel (invalid lanes 0)
//   px_data_val_o  : per-lane valid
//   line_start_o   : first word of an active line
//   line_end_o     : last word of an active line
//   frame_start_o  : first word of the frame (line 0, word 0)
//   frame_end_o    : last word of the last active line
// All outputs are registered; blanking and idle words are all zero.
// -----------------------------------------------------------------------------
module video_pattern_gen
    import video_gen_pkg::*;
#(
    parameter int PX_WIDTH   = 12,
    parameter int PX_PER_CLK = 4,
    parameter int RES_X      = 1936,
    parameter int TOTAL_X    = 2200,
    parameter int RES_Y      = 1096,
    parameter int TOTAL_Y    = 1125
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [1:0]                     pattern_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o
);

    localparam int W_ACT = ceil_div(RES_X, PX_PER_CLK);
    localparam int W_TOT = TOTAL_X / PX_PER_CLK;

    // Counter widths hold the totals themselves so that the "active" compares
    // stay correct when there is no blanking (RES == TOTAL).
    localparam int X_W  = max_int($clog2(W_TOT + 1), 1);
    localparam int Y_W  = max_int($clog2(TOTAL_Y + 1), 1);
    localparam int P_W  = max_int($clog2(TOTAL_X), CHECKER_BIT + 1);
    localparam int YP_W = max_int(Y_W, CHECKER_BIT + 1);

    localparam logic [X_W-1:0] X_LAST     = X_W'(W_TOT - 1);
    localparam logic [X_W-1:0] X_ACT      = X_W'(W_ACT);
    localparam logic [X_W-1:0] X_ACT_LAST = X_W'(W_ACT - 1);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(TOTAL_Y - 1);
    localparam logic [Y_W-1:0] Y_ACT      = Y_W'(RES_Y);
    localparam logic [Y_W-1:0] Y_ACT_LAST = Y_W'(RES_Y - 1);

    localparam logic [PX_PER_CLK-1:0] LAST_MASK =
        PX_PER_CLK'(last_word_mask(RES_X, PX_PER_CLK));

    // ---------------------------------------------------------------------
    // Geometry sanity checks
    // ---------------------------------------------------------------------
    if (TOTAL_X % PX_PER_CLK != 0) begin : g_chk_total_x
        $error("TOTAL_X must be a multiple of PX_PER_CLK");
    end
    if (RES_X > TOTAL_X) begin : g_chk_res_x
        $error("RES_X must not exceed TOTAL_X");
    end
    if (RES_Y > TOTAL_Y) begin : g_chk_res_y
        $error("RES_Y must not exceed TOTAL_Y");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    gen_state_t     state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    pattern_t       pat_q;

    // ---------------------------------------------------------------------
    // Per-lane pixel values for the word at (x, y)
    // ---------------------------------------------------------------------
    logic [PX_WIDTH-1:0] lane_px [PX_PER_CLK];

    for (genvar l = 0; l < PX_PER_CLK; l++) begin : g_lane
        logic [P_W-1:0] p;

        assign p = P_W'(x) * P_W'(PX_PER_CLK) + P_W'(l);

        video_pattern_px #(
            .PX_WIDTH (PX_WIDTH),
            .P_W      (P_W),
            .Y_W      (YP_W)
        ) u_px (
            .pattern (pat_q),
            .p       (p),
            .y       (YP_W'(y)),
            .px      (lane_px[l])
        );
    end

    // ---------------------------------------------------------------------
    // Next output word
    // ---------------------------------------------------------------------
    logic                           active;
    logic                           last_word;
    logic                           line_start_d;
    logic                           line_end_d;
    logic [PX_PER_CLK-1:0]          val_d;
    logic [PX_PER_CLK*PX_WIDTH-1:0] data_d;

    always_comb begin
        active       = (state == ST_RUN) && (y < Y_ACT) && (x < X_ACT);
        last_word    = (x == X_ACT_LAST);
        line_start_d = active && (x == '0);
        line_end_d   = active && last_word;
        val_d        = '0;
        data_d       = '0;
        if (active) begin
            val_d = last_word ? LAST_MASK : '1;
        end
        for (int l = 0; l < PX_PER_CLK; l++) begin
            if (val_d[l]) begin
                data_d[l*PX_WIDTH +: PX_WIDTH] = lane_px[l];
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM, raster counters and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            x             <= '0;
            y             <= '0;
            pat_q         <= PAT_HRAMP;
            px_data_o     <= '0;
            px_data_val_o <= '0;
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every term on the right reads the pre-edge value of state/x/y.
            px_data_o     <= data_d;
            px_data_val_o <= val_d;
            line_start_o  <= line_start_d;
            line_end_o    <= line_end_d;
            frame_start_o <= line_start_d && (y == '0);
            frame_end_o   <= line_end_d && (y == Y_ACT_LAST);

            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        state <= ST_RUN;
                        pat_q <= pattern_t'(pattern_i);
                    end
                end
                ST_RUN: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            // Frame boundary: the only point where en_i and
                            // pattern_i are honoured while running.
                            y <= '0;
                            if (en_i) begin
                                pat_q <= pattern_t'(pattern_i);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
// Three generator instances share one clock:
//   A : 100x40 active in 128x45 total, spot-checked against a vector table
//       of captured frames, plus start latency and frame period.
//   B : 10x3 active in 16x5 total (partial last word), every output word
//       compared through a scoreboard queue filled from a raster model.
//   C : 3x2 active in 4x2 total (one word per line, no vertical blanking),
//       scoreboard as for B.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

    localparam int PPC  = 4;
    localparam int PXW  = 12;

    localparam int A_RX = 100, A_TX = 128, A_RY = 40, A_TY = 45;
    localparam int B_RX = 10,  B_TX = 16,  B_RY = 3,  B_TY = 5;
    localparam int C_RX = 3,   C_TX = 4,   C_RY = 2,  C_TY = 2;

    localparam int A_WT    = A_TX / PPC;
    localparam int A_WORDS = A_WT * A_TY;
    localparam int B_WORDS = (B_TX / PPC) * B_TY;
    localparam int C_WORDS = (C_TX / PPC) * C_TY;

    typedef logic [55:0] word_t;   // {data[47:0], val[3:0], ls, le, fs, fe}

    typedef struct {
        int    pat;
        int    y;
        int    x;
        word_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ac, rst_b;
    logic en_a, en_b, en_c;
    logic [1:0] pat_a, pat_b, pat_c;

    logic [PPC*PXW-1:0] data_a, data_b, data_c;
    logic [PPC-1:0]     val_a, val_b, val_c;
    logic ls_a, le_a, fs_a, fe_a;
    logic ls_b, le_b, fs_b, fe_b;
    logic ls_c, le_c, fs_c, fe_c;

    word_t out_a, out_b, out_c;
    assign out_a = {data_a, val_a, ls_a, le_a, fs_a, fe_a};
    assign out_b = {data_b, val_b, ls_b, le_b, fs_b, fe_b};
    assign out_c = {data_c, val_c, ls_c, le_c, fs_c, fe_c};

    video_pattern_gen #(
        .PX_WIDTH(PXW), .PX_PER_CLK(PPC),
        .RES_X(A_RX), .TOTAL_X(A_TX), .RES_Y(A_RY), .TOTAL_Y(A_TY)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst_ac), .en_i(en_a), .pattern_i(pat_a),
        .px_data_o(data_a), .px_data_val_o(val_a),
        .line_start_o(ls_a), .line_end_o(le_a),
        .frame_start_o(fs_a), .frame_end_o(fe_a)
    );

    video_pattern_gen #(
        .PX_WIDTH(PXW), .PX_PER_CLK(PPC),
        .RES_X(B_RX), .TOTAL_X(B_TX), .RES_Y(B_RY), .TOTAL_Y(B_TY)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .pattern_i(pat_b),
        .px_data_o(data_b), .px_data_val_o(val_b),
        .line_start_o(ls_b), .line_end_o(le_b),
        .frame_start_o(fs_b), .frame_end_o(fe_b)
    );

    video_pattern_gen #(
        .PX_WIDTH(PXW), .PX_PER_CLK(PPC),
        .RES_X(C_RX), .TOTAL_X(C_TX), .RES_Y(C_RY), .TOTAL_Y(C_TY)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst_ac), .en_i(en_c), .pattern_i(pat_c),
        .px_data_o(data_c), .px_data_val_o(val_c),
        .line_start_o(ls_c), .line_end_o(le_c),
        .frame_start_o(fs_c), .frame_end_o(fe_c)
    );

    int n_cmp = 0;
    int n_err = 0;
    int b_idx = 0;
    int c_idx = 0;

    word_t q_b[$];
    word_t q_c[$];
    word_t cap [A_WORDS];
    vec_t  tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Raster model: a lane is valid when its pixel index lies inside the line.
    function automatic word_t model_word(input int pat, input int xx, input int yy,
                                         input int res_x, input int res_y);
        logic [47:0] d;
        logic [3:0]  v;
        logic        act, ls, le, fs, fe;
        int          pix, pv;
        d   = '0;
        v   = '0;
        act = (yy < res_y) && (xx * PPC < res_x);
        for (int l = 0; l < PPC; l++) begin
            pix = xx * PPC + l;
            if (act && pix < res_x) begin
                v[l] = 1'b1;
                case (pat)
                    0:       pv = pix;
                    1:       pv = yy;
                    2:       pv = (((pix >> 5) ^ (yy >> 5)) & 1) != 0 ? 4095 : 0;
                    default: pv = pix ^ yy;
                endcase
                d[l*PXW +: PXW] = pv[11:0];
            end
        end
        ls = act && (xx == 0);
        le = act && (xx * PPC + PPC >= res_x);
        fs = ls && (yy == 0);
        fe = le && (yy == res_y - 1);
        return {d, v, ls, le, fs, fe};
    endfunction

    function automatic word_t mk(input int l3, input int l2, input int l1, input int l0,
                                 input logic [3:0] v, input logic ls, input logic le,
                                 input logic fs, input logic fe);
        return {12'(l3), 12'(l2), 12'(l1), 12'(l0), v, ls, le, fs, fe};
    endfunction

    task automatic push_idle(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst == 1) q_b.push_back('0);
            else           q_c.push_back('0);
        end
    endtask

    task automatic push_frame(input int inst, input int pat, input int n_words);
        int rx, tx, ry, ty, cnt;
        word_t w;
        if (inst == 1) begin
            rx = B_RX; tx = B_TX; ry = B_RY; ty = B_TY;
        end else begin
            rx = C_RX; tx = C_TX; ry = C_RY; ty = C_TY;
        end
        cnt = 0;
        for (int yy = 0; yy < ty; yy++) begin
            for (int xx = 0; xx < tx / PPC; xx++) begin
                if (cnt < n_words) begin
                    w = model_word(pat, xx, yy, rx, ry);
                    if (inst == 1) q_b.push_back(w);
                    else           q_c.push_back(w);
                    cnt++;
                end
            end
        end
    endtask

    // One clock: sample at the falling edge and retire one expected word per
    // active scoreboard. Inputs are changed by the caller after this returns.
    task automatic tick();
        word_t e;
        @(negedge clk);
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check($sformatf("b_word%0d", b_idx), out_b, e);
            b_idx++;
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check($sformatf("c_word%0d", c_idx), out_c, e);
            c_idx++;
        end
    endtask

    task automatic drain();
        while (q_b.size() > 0 || q_c.size() > 0) tick();
    endtask

    // Start instance A with the given pattern, check the start latency, and
    // capture one complete frame. en_a drops right after frame start, so the
    // frame must still finish and the generator must then sit idle.
    task automatic capture_a(input int pat);
        int  lat;
        bit  seen;
        pat_a = 2'(pat);
        en_a  = 1'b1;
        lat   = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (fs_a) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check($sformatf("a_start_latency_pat%0d", pat), lat, 2);
        en_a   = 1'b0;
        cap[0] = out_a;
        for (int k = 1; k < A_WORDS; k++) begin
            @(negedge clk);
            cap[k] = out_a;
        end
        repeat (3) @(negedge clk);
        check($sformatf("a_idle_after_pat%0d", pat), out_a, '0);
    endtask

    initial begin
        int cur_pat;
        int cnt;
        bit seen;

        tbl[0]  = '{0, 0,  0,  mk(3, 2, 1, 0, 4'hF, 1, 0, 1, 0)};
        tbl[1]  = '{0, 0,  24, mk(99, 98, 97, 96, 4'hF, 0, 1, 0, 0)};
        tbl[2]  = '{0, 0,  25, '0};
        tbl[3]  = '{0, 39, 24, mk(99, 98, 97, 96, 4'hF, 0, 1, 0, 1)};
        tbl[4]  = '{0, 40, 0,  '0};
        tbl[5]  = '{1, 7,  3,  mk(7, 7, 7, 7, 4'hF, 0, 0, 0, 0)};
        tbl[6]  = '{1, 39, 0,  mk(39, 39, 39, 39, 4'hF, 1, 0, 0, 0)};
        tbl[7]  = '{2, 0,  7,  mk(0, 0, 0, 0, 4'hF, 0, 0, 0, 0)};
        tbl[8]  = '{2, 0,  8,  mk(4095, 4095, 4095, 4095, 4'hF, 0, 0, 0, 0)};
        tbl[9]  = '{2, 32, 7,  mk(4095, 4095, 4095, 4095, 4'hF, 0, 0, 0, 0)};
        tbl[10] = '{2, 32, 8,  mk(0, 0, 0, 0, 4'hF, 0, 0, 0, 0)};
        tbl[11] = '{3, 1,  0,  mk(2, 3, 0, 1, 4'hF, 1, 0, 0, 0)};
        tbl[12] = '{3, 5,  10, mk(46, 47, 44, 45, 4'hF, 0, 0, 0, 0)};
        tbl[13] = '{3, 0,  31, '0};

        rst_ac = 1'b1; rst_b = 1'b1;
        en_a = 1'b0;  en_b = 1'b0;  en_c = 1'b0;
        pat_a = 2'd0; pat_b = 2'd0; pat_c = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        push_idle(1, 1);
        push_idle(2, 1);
        tick();
        check("a_reset_state", out_a, '0);
        rst_ac = 1'b0;
        rst_b  = 1'b0;
        push_idle(1, 2);
        push_idle(2, 2);
        drain();

        // B: H-ramp frame, pattern switched to XOR mid-frame (takes effect
        // on the seamless next frame), en dropped mid-frame of frame two.
        pat_b = 2'd0;
        en_b  = 1'b1;
        push_idle(1, 1);
        push_frame(1, 0, B_WORDS);
        push_frame(1, 3, B_WORDS);
        repeat (8) tick();
        pat_b = 2'd3;
        while (q_b.size() > 10) tick();
        en_b = 1'b0;
        drain();
        push_idle(1, 4);
        drain();

        // B: restart with V-ramp, reset in the middle of line 1 (the line
        // end that would follow must not appear), then a clean new frame.
        pat_b = 2'd1;
        en_b  = 1'b1;
        push_idle(1, 1);
        push_frame(1, 1, 6);
        drain();
        rst_b = 1'b1;
        push_idle(1, 1);
        tick();
        rst_b = 1'b0;
        push_idle(1, 1);
        push_frame(1, 1, B_WORDS);
        while (q_b.size() > 1) tick();
        en_b = 1'b0;
        drain();
        push_idle(1, 3);
        drain();

        // C: one word per line, no vertical blanking, back-to-back frames.
        pat_c = 2'd0;
        en_c  = 1'b1;
        push_idle(2, 1);
        push_frame(2, 0, C_WORDS);
        push_frame(2, 3, C_WORDS);
        tick();
        pat_c = 2'd3;
        while (q_c.size() > 1) tick();
        en_c = 1'b0;
        drain();
        push_idle(2, 3);
        drain();

        // A: vector table against captured frames, one capture per pattern.
        cur_pat = -1;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].pat != cur_pat) begin
                cur_pat = tbl[i].pat;
                capture_a(cur_pat);
            end
            check($sformatf("a_vec%0d_pat%0d_y%0d_x%0d", i, tbl[i].pat, tbl[i].y, tbl[i].x),
                  cap[tbl[i].y * A_WT + tbl[i].x], tbl[i].exp);
        end

        // A: frame period with en held high.
        pat_a = 2'd0;
        en_a  = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = fs_a;
        end
        check("a_first_frame_start", 64'(seen), 64'd1);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 3 * A_WORDS && !seen; i++) begin
            @(negedge clk);
            if (fs_a) begin
                seen = 1'b1;
                cnt  = i;
            end
        end
        check("a_frame_period", cnt, A_WORDS);
        en_a = 1'b0;
        repeat (A_WORDS + 4) @(negedge clk);
        check("a_idle_after_period", out_a, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Synthesizable video stream transmitter producing the pixel-stream protocol consumed by `video_stream_to_window` and the other stream sinks. It emits PX_PER_CLK pixels per clock with per-lane valid mask and line/frame markers, inserts horizontal and vertical blanking per TOTAL_X/TOTAL_Y, and fills active pixels from a selectable test pattern. It is used as an on-chip stimulus source and as a replacement for testbench stream drivers.

## Interface
- PX_WIDTH, 12, bits per pixel
- PX_PER_CLK, 4, pixels per word (lanes)
- RES_X, 1936, active pixels per line
- TOTAL_X, 2200, total pixels per line incl. blanking; must be a multiple of PX_PER_CLK
- RES_Y, 1096, active lines per frame
- TOTAL_Y, 1125, total lines per frame incl. blanking
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  run request, sampled at frame boundaries only
- pattern_i  in  2  pattern select, latched at frame start
- px_data_o  out  PX_PER_CLK*PX_WIDTH  pixel lanes, lane 0 = leftmost pixel
- px_data_val_o  out  PX_PER_CLK  per-lane valid
- line_start_o  out  1  first word of an active line
- line_end_o  out  1  last word of an active line
- frame_start_o  out  1  first word of frame (line 0, word 0)
- frame_end_o  out  1  last word of last active line

## Operation
- Derived: W_ACT = ceil(RES_X/PX_PER_CLK), W_TOT = TOTAL_X/PX_PER_CLK, REM = RES_X % PX_PER_CLK.
- FSM IDLE/RUN. IDLE: counters held at 0, all outputs 0. IDLE and en_i=1 → RUN, pattern latched.
- RUN: word counter x in 0..W_TOT-1, line counter y in 0..TOTAL_Y-1; x wraps to 0 and y increments; y wraps at TOTAL_Y-1.
- At last word of frame (x=W_TOT-1, y=TOTAL_Y-1): en_i=1 → stay RUN, x=y=0, re-latch pattern (seamless next frame); en_i=0 → IDLE. en_i ignored at all other times.
- Active word: y<RES_Y and x<W_ACT. Blanking: all outputs 0.
- px_data_val_o: all ones on active words, except last word when REM≠0: low REM bits set ((1<<REM)-1), upper lanes 0.
- line_start_o = active & x=0; line_end_o = active & x=W_ACT-1; frame_start_o = line_start_o & y=0; frame_end_o = line_end_o & y=RES_Y-1.
- Pixel index p = x*PX_PER_CLK+lane; values truncated to PX_WIDTH LSBs. Patterns: 0 H-ramp = p; 1 V-ramp = y; 2 checker = all ones if p[5]^y[5] else 0; 3 XOR = p^y. Invalid lanes drive 0.

## Timing
- All outputs registered; reset value 0 for every output; FSM → IDLE, counters 0.
- Latency: en_i=1 sampled at edge k in IDLE → frame_start_o high in cycle after edge k+1.
- One word per clock in RUN, no backpressure; frame period exactly W_TOT*TOTAL_Y cycles.
- rst_i mid-frame: outputs 0 after that edge, stream resumes only via a new en_i start with frame_start_o.
- pattern_i changes mid-frame have no effect until next frame start.
- Degenerate: RES_X=TOTAL_X (no H-blank) and RES_Y=TOTAL_Y (no V-blank) supported; W_ACT=1 gives line_start_o and line_end_o on same word.

## Structure
- Package video_gen_pkg: pattern_t enum (PAT_HRAMP, PAT_VRAMP, PAT_CHECKER, PAT_XOR), helper function for W_ACT ceil-div and last-word mask.
- Elaboration-time checks: TOTAL_X%PX_PER_CLK=0, RES_X≤TOTAL_X, RES_Y≤TOTAL_Y.
- One combinational sub-module video_pattern_px: (pattern, p, y) → pixel; instantiated per lane.

## Test plan
- Defaults, en_i held 1, pattern 0: frame_start_o two cycles after en; 484 active words/line, last word val=4'b1111; lane values 0..1935 per line; 1125*550 cycles between frame_start_o pulses.
- RES_X=10, TOTAL_X=16, PX_PER_CLK=4, RES_Y=3, TOTAL_Y=5: last word val=4'b0011, data lanes 2,3 = 0; frame_end_o on y=2,x=2 only.
- en_i dropped mid-frame: frame completes incl. blanking, then outputs stay 0; re-raise → new frame_start_o.
- pattern_i switched 0→3 mid-frame: current frame stays H-ramp; next frame XOR (line 1 word 0 = 1,0,3,2).
- rst_i pulse mid-line: all outputs 0 next cycle, no line_end_o; next frame begins with frame_start_o at y=0.
- Pattern 2, RES_X≥64: pixel 31 = 0, pixel 32 = 12'hFFF on line 0; inverted on line 32.
